// File: rtl/dmem_pkg.sv
// Shared types for the data-memory controller: FSM states and the power-on
// preset table that the INIT sequencer replays after reset or soft clear.
package dmem_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    BUSY = 2'd2,
    RESP = 2'd3
  } dmem_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] value;
  } preset_entry_t;

  localparam int PRESET_N = 3;

  localparam preset_entry_t DMEM_PRESET [PRESET_N] = '{
    '{addr: 32'd0, value: 32'd5},
    '{addr: 32'd1, value: 32'd7},
    '{addr: 32'd4, value: 32'd3}
  };

  // Words not listed in the table initialise to zero.
  function automatic logic [31:0] preset_value(input logic [31:0] addr);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < PRESET_N; k++) begin
      if (DMEM_PRESET[k].addr == addr) v = DMEM_PRESET[k].value;
    end
    return v;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port storage: synchronous write, asynchronous read, no reset so the
// array stays inferable as RAM.
module dmem_array #(
  parameter int DATA_W = 19,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_ctrl.sv
// Load/store controller for the CPU data memory: valid/ready request and
// response channels, configurable read latency, range check, preset sequencer.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W   = 19,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              soft_clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both 1; a response transfers where rsp_valid and rsp_ready
  // are both 1. Only one request is ever outstanding.

  localparam int CNT_W = 2;
  // BUSY lasts READ_LAT-1 cycles; the counter runs down to zero.
  localparam logic [CNT_W-1:0] BUSY_LOAD = (READ_LAT >= 2) ? CNT_W'(READ_LAT - 2) : '0;

  dmem_state_t       state, state_next;
  logic [ADDR_W-1:0] init_cnt;
  logic [ADDR_W-1:0] cap_addr;
  logic              cap_err;
  logic [CNT_W-1:0]  lat_cnt;
  logic              req_oob;
  logic              init_last;

  logic              arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign req_oob   = {1'b0, req_addr} >= (ADDR_W + 1)'(DEPTH);
  assign init_last = (init_cnt == ADDR_W'(DEPTH - 1));

  always_comb begin
    state_next = state;
    arr_we     = 1'b0;
    arr_addr   = cap_addr;
    arr_wdata  = req_wdata;
    case (state)
      INIT: begin
        arr_we    = 1'b1;
        arr_addr  = init_cnt;
        arr_wdata = DATA_W'(preset_value(32'(init_cnt)));
        if (init_last) state_next = IDLE;
      end
      IDLE: begin
        arr_addr = req_addr;
        if (soft_clear) begin
          state_next = INIT;
        end else if (req_valid) begin
          arr_we     = req_we && !req_oob;
          state_next = (req_we || READ_LAT == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (lat_cnt == '0) state_next = RESP;
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= INIT;
      init_cnt  <= '0;
      cap_addr  <= '0;
      cap_err   <= 1'b0;
      lat_cnt   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        INIT: begin
          if (init_last) begin
            init_cnt  <= '0;
            init_done <= 1'b1;
          end else begin
            init_cnt <= init_cnt + ADDR_W'(1);
          end
        end
        IDLE: begin
          if (soft_clear) begin
            init_cnt  <= '0;
            init_done <= 1'b0;
          end else if (req_valid) begin
            cap_addr <= req_addr;
            cap_err  <= req_oob;
            lat_cnt  <= BUSY_LOAD;
            if (req_we) begin
              rsp_rdata <= '0;
              rsp_err   <= req_oob;
            end else if (READ_LAT == 1) begin
              rsp_rdata <= req_oob ? '0 : arr_rdata;
              rsp_err   <= req_oob;
            end
          end
        end
        BUSY: begin
          // Array address is the captured one here, so arr_rdata is the load data.
          if (lat_cnt == '0) begin
            rsp_rdata <= cap_err ? '0 : arr_rdata;
            rsp_err   <= cap_err;
          end else begin
            lat_cnt <= lat_cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  dmem_array #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .addr (arr_addr),
    .wdata(arr_wdata),
    .rdata(arr_rdata)
  );

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: two instances (default, and DEPTH=12/READ_LAT=3) share
// one stimulus bus selected by sel; a word-array model predicts every response.
module tb_dmem_ctrl;

  localparam int DW = 19;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          soft_clear, req_valid, req_we, rsp_ready;
  logic [3:0]    req_addr;
  logic [DW-1:0] req_wdata;
  int            sel;

  logic          a_req_ready, a_rsp_valid, a_rsp_err, a_init_done;
  logic [DW-1:0] a_rsp_rdata;
  logic          b_req_ready, b_rsp_valid, b_rsp_err, b_init_done;
  logic [DW-1:0] b_rsp_rdata;

  logic          req_ready, rsp_valid, rsp_err, init_done;
  logic [DW-1:0] rsp_rdata;

  assign req_ready = (sel == 0) ? a_req_ready : b_req_ready;
  assign rsp_valid = (sel == 0) ? a_rsp_valid : b_rsp_valid;
  assign rsp_err   = (sel == 0) ? a_rsp_err   : b_rsp_err;
  assign init_done = (sel == 0) ? a_init_done : b_init_done;
  assign rsp_rdata = (sel == 0) ? a_rsp_rdata : b_rsp_rdata;

  dmem_ctrl u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .soft_clear(soft_clear && sel == 0),
    .req_valid (req_valid && sel == 0),
    .req_ready (a_req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (a_rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (a_rsp_rdata),
    .rsp_err   (a_rsp_err),
    .init_done (a_init_done)
  );

  dmem_ctrl #(
    .DEPTH   (12),
    .READ_LAT(3)
  ) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .soft_clear(soft_clear && sel == 1),
    .req_valid (req_valid && sel == 1),
    .req_ready (b_req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (b_rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (b_rsp_rdata),
    .rsp_err   (b_rsp_err),
    .init_done (b_init_done)
  );

  // ---------------- scoreboard / model ----------------
  int errors = 0;
  int checks = 0;
  logic [DW-1:0] mem_m [2][16];
  logic [DW:0]   exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (sel=%0d): got 0x%0h expected 0x%0h", tag, sel, got, exp);
    end
  endtask

  function automatic int depth_of(input int s);
    return (s == 0) ? 16 : 12;
  endfunction

  function automatic int lat_of(input int s);
    return (s == 0) ? 1 : 3;
  endfunction

  task automatic model_init(input int s);
    for (int i = 0; i < 16; i++) mem_m[s][i] = '0;
    mem_m[s][0] = 19'd5;
    mem_m[s][1] = 19'd7;
    mem_m[s][4] = 19'd3;
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_init(input int exp_cycles, input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!init_done && n < 200);
    check(tag, n, exp_cycles);
  endtask

  // One request/response; hold = cycles rsp_ready stays low once RESP is seen.
  task automatic do_req(input bit we, input logic [3:0] addr, input logic [DW-1:0] wd,
                        input int hold);
    int            n;
    bit            err_m;
    logic [DW-1:0] exp_data;
    logic [DW:0]   exp;
    @(negedge clk);
    rsp_ready = (hold == 0);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      return;
    end
    err_m    = int'(addr) >= depth_of(sel);
    exp_data = (we || err_m) ? '0 : mem_m[sel][addr];
    exp_q.push_back({err_m, exp_data});
    if (we && !err_m) mem_m[sel][addr] = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    exp = exp_q.pop_front();
    check("rsp_latency", n, we ? 1 : lat_of(sel));
    if (!rsp_valid) begin
      rsp_ready = 1'b1;
      return;
    end
    check("rsp_rdata", rsp_rdata, exp[DW-1:0]);
    check("rsp_err", rsp_err, exp[DW]);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_rdata", rsp_rdata, exp[DW-1:0]);
      check("hold_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("rsp_clear", {rsp_valid, rsp_err, rsp_rdata}, 0);
    check("back_idle", req_ready, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset      = 1'b1;
    soft_clear = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    rsp_ready  = 1'b1;
    sel        = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      check("reset_outputs", {req_ready, rsp_valid, rsp_err, init_done, rsp_rdata}, 0);
    end
    sel = 0;
    model_init(0);
    model_init(1);
    @(negedge clk);
    reset = 1'b0;
    wait_init(16, "init_cycles_a");
    check("init_done_b", b_init_done, 1);

    // Preset contents and store/load round trip on the default instance.
    do_req(1'b0, 4'd0, '0, 0);
    do_req(1'b0, 4'd1, '0, 0);
    do_req(1'b0, 4'd4, '0, 0);
    do_req(1'b0, 4'd9, '0, 0);
    do_req(1'b1, 4'd2, 19'h7ABCD, 0);
    do_req(1'b0, 4'd2, '0, 0);
    repeat (30) do_req(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                       DW'($urandom), $urandom_range(0, 2));

    // Out-of-range handling and long read latency on the 12-word instance.
    sel = 1;
    do_req(1'b0, 4'd13, '0, 0);
    do_req(1'b1, 4'd13, 19'h55555, 0);
    for (int i = 0; i < 12; i++) do_req(1'b0, 4'(i), '0, 0);
    do_req(1'b0, 4'd4, '0, 5);
    repeat (30) do_req(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                       DW'($urandom), $urandom_range(0, 2));

    // Soft clear beats a simultaneous request and rebuilds presets.
    sel = 0;
    do_req(1'b1, 4'd0, 19'h1, 0);
    do_req(1'b0, 4'd0, '0, 0);
    @(negedge clk);
    soft_clear = 1'b1;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_addr   = 4'd3;
    req_wdata  = 19'h12345;
    @(posedge clk);
    #1;
    soft_clear = 1'b0;
    req_valid  = 1'b0;
    check("sc_ready", req_ready, 0);
    check("sc_init_done", init_done, 0);
    check("sc_no_rsp", rsp_valid, 0);
    wait_init(16, "sc_init_cycles");
    model_init(0);
    do_req(1'b0, 4'd0, '0, 0);
    do_req(1'b0, 4'd3, '0, 0);

    // Reset while a load is in BUSY discards it and restarts INIT.
    sel = 1;
    do_req(1'b1, 4'd0, 19'h3FFFF, 0);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 4'd4;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("busy_no_valid", rsp_valid, 0);
    reset = 1'b1;
    #1;
    check("rst_init_done", init_done, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    check("rst_hold_valid", rsp_valid, 0);
    reset = 1'b0;
    model_init(0);
    model_init(1);
    wait_init(12, "rst_init_cycles_b");
    do_req(1'b0, 4'd0, '0, 0);
    do_req(1'b0, 4'd4, '0, 0);
    sel = 0;
    do_req(1'b0, 4'd1, '0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
